iexec_core: RTL

Parametrised successor to the single-step fetch/ALU demo path. A multi-cycle core executes RV32I OP-IMM instructions from an external combinational instruction ROM. It holds a 32-entry register file, and instructions advance either on a free-running divided tick (run mode) or on a single-cycle step pulse (step mode). The last write-back result, destination and PC are exported for the seven-segment display path.

---
 rtl/iexec_core.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/iexec_core.sv
`default_nettype none
// ============================================================================
//  Module   : iexec_core
//  Brief    : Multi-cycle RV32I OP-IMM core with run/step sequencing, a
//             32-entry register file and a write-back display export.
//  Revision : 1.0 - initial release
// ============================================================================
module iexec_core #(
    parameter int CLK_DIV   = 50000000,
    parameter int MEM_WORDS = 16,
    parameter int NREGS     = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        run,
    input  logic        step_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_out,
    output logic [31:0] result,
    output logic [4:0]  result_rd,
    output logic        result_valid,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int                 c_CNT_W    = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [31:0]        c_PC_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [31:0]        c_NREGS    = 32'(NREGS);
    localparam logic [6:0]         c_OP_IMM   = 7'b0010011;
    localparam logic [6:0]         c_F7_ZERO  = 7'b0000000;
    localparam logic [6:0]         c_F7_SRA   = 7'b0100000;

    localparam logic [1:0] c_ST_WAIT  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_EXEC  = 2'd2;
    localparam logic [1:0] c_ST_WB    = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [31:0]        r_result;
    logic [4:0]         r_result_rd;
    logic               r_wr_en;
    logic               r_valid;
    logic               r_illegal;
    logic [31:0]        r_regs [NREGS];

    logic               w_tick;
    logic               w_trigger;
    logic [6:0]         w_opcode;
    logic [4:0]         w_rd;
    logic [2:0]         w_funct3;
    logic [4:0]         w_rs1;
    logic [6:0]         w_funct7;
    logic [4:0]         w_shamt;
    logic [31:0]        w_imm;
    logic [31:0]        w_rs1_val;
    logic [31:0]        w_alu;
    logic               w_bad;
    logic [31:0]        w_pc_inc;
    logic [31:0]        w_pc_next;

    assign w_tick    = (r_cnt == c_CNT_MAX);
    assign w_trigger = run ? w_tick : step_req;

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_funct3 = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_shamt  = r_instr[24:20];
    assign w_funct7 = r_instr[31:25];
    assign w_imm    = {{20{r_instr[31]}}, r_instr[31:20]};

    // x0 and any address beyond the implemented registers read as zero
    assign w_rs1_val = (w_rs1 != 5'd0 && {27'd0, w_rs1} < c_NREGS) ? r_regs[w_rs1] : 32'd0;
    assign dbg_data  = (dbg_addr != 5'd0 && {27'd0, dbg_addr} < c_NREGS) ? r_regs[dbg_addr] : 32'd0;

    assign w_pc_inc  = r_pc + 32'd4;
    assign w_pc_next = (w_pc_inc >= c_PC_LIMIT) ? 32'd0 : w_pc_inc;

    always_comb begin
        w_alu = 32'd0;
        w_bad = 1'b0;
        if (w_opcode != c_OP_IMM) begin
            w_bad = 1'b1;
        end else begin
            case (w_funct3)
                3'b000: w_alu = w_rs1_val + w_imm;
                3'b010: w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_imm)};
                3'b011: w_alu = {31'd0, w_rs1_val < w_imm};
                3'b100: w_alu = w_rs1_val ^ w_imm;
                3'b110: w_alu = w_rs1_val | w_imm;
                3'b111: w_alu = w_rs1_val & w_imm;
                3'b001: begin
                    if (w_funct7 == c_F7_ZERO) w_alu = w_rs1_val << w_shamt;
                    else                       w_bad = 1'b1;
                end
                3'b101: begin
                    if (w_funct7 == c_F7_ZERO)     w_alu = w_rs1_val >> w_shamt;
                    else if (w_funct7 == c_F7_SRA) w_alu = 32'($signed(w_rs1_val) >>> w_shamt);
                    else                           w_bad = 1'b1;
                end
                default: w_bad = 1'b1;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state     <= c_ST_WAIT;
            r_cnt       <= '0;
            r_pc        <= 32'd0;
            r_instr     <= 32'd0;
            r_result    <= 32'd0;
            r_result_rd <= 5'd0;
            r_wr_en     <= 1'b0;
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'd0;
        end else begin
            r_cnt     <= w_tick ? '0 : r_cnt + c_CNT_ONE;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                c_ST_WAIT: begin
                    if (w_trigger) r_state <= c_ST_FETCH;
                end
                c_ST_FETCH: begin
                    r_instr <= imem_data;
                    r_state <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    // result/valid register here so they are visible throughout WB
                    r_result    <= w_bad ? 32'd0 : w_alu;
                    r_result_rd <= w_rd;
                    r_wr_en     <= !w_bad && w_rd != 5'd0 && {27'd0, w_rd} < c_NREGS;
                    r_valid     <= 1'b1;
                    r_illegal   <= w_bad;
                    r_state     <= c_ST_WB;
                end
                c_ST_WB: begin
                    if (r_wr_en) r_regs[r_result_rd] <= r_result;
                    r_pc    <= w_pc_next;
                    r_state <= c_ST_WAIT;
                end
                default: r_state <= c_ST_WAIT;
            endcase
        end
    end

    assign imem_addr    = r_pc;
    assign pc_out       = r_pc;
    assign result       = r_result;
    assign result_rd    = r_result_rd;
    assign result_valid = r_valid;
    assign illegal      = r_illegal;

endmodule
`default_nettype wire
